// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin hold arbiter.
//   arb_state_e : two-state FSM encoding (idle / grant active)
//   rot_mask()  : mask of bit positions strictly above a pointer (up to 32 clients)
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Bits strictly above ptr are set. ptr=31 yields an empty mask, which is
  // what makes selection fall back to the plain lowest-set-bit scan.
  function automatic logic [31:0] rot_mask(input logic [4:0] ptr);
    logic [32:0] bit_up;
    logic [32:0] below;
    bit_up = 33'd1 << ({1'b0, ptr} + 6'd1);
    below  = bit_up - 33'd1;
    return ~below[31:0];
  endfunction

endpackage

// File: rtl/find_first_set.sv
// Common priority scan: reports the lowest set bit of vec.
//   vec : input vector
//   idx : 1-based position of the lowest set bit, 0 when vec is all zero
module find_first_set #(
  parameter int W  = 8,
  parameter int OW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [OW-1:0] idx
);

  // Scan high to low so the lowest set bit is the last writer.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = OW'(i + 1);
    end
  end

endmodule

// File: rtl/arbiter_rr_hold.sv
// Round-robin arbiter with grant hold. The owner keeps the grant until it
// acks, drops its request, or has held it for MAX_HOLD cycles (0 = no limit).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req          : per-client level requests
//   i_ack          : owner's transaction-complete strobe
//   o_grant        : registered one-hot grant
//   o_grant_id     : registered binary index of the owner
//   o_grant_valid  : a grant is active
//   o_timeout      : pulse in the cycle a grant is force-released by the hold limit
module arbiter_rr_hold
  import arb_pkg::*;
#(
  parameter int CLIENTS  = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(CLIENTS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [CLIENTS-1:0] i_req,
  input  logic               i_ack,
  output logic [CLIENTS-1:0] o_grant,
  output logic [IDW-1:0]     o_grant_id,
  output logic               o_grant_valid,
  output logic               o_timeout
);

  localparam int FW        = $clog2(CLIENTS + 1);
  localparam int CW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam int CNT_MAX   = (MAX_HOLD > 0) ? MAX_HOLD : 1;

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     id_q, id_d, last_q, last_d, sel_ptr, win;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CLIENTS-1:0] mask, masked, grant_q, grant_d;
  logic [FW-1:0]      ffs_m, ffs_u, win_1b;
  logic               has_win, rel_ack, rel_drop, rel_to;

  // While granted, the only time selection matters is on release, when the
  // pointer becomes the current owner; using id_q directly lets the next
  // winner be chosen in the same cycle with the owner at lowest priority.
  assign sel_ptr = (state_q == ARB_GRANT) ? id_q : last_q;
  assign mask    = CLIENTS'(rot_mask(5'(sel_ptr)));
  assign masked  = i_req & mask;

  find_first_set #(.W(CLIENTS), .OW(FW)) u_ffs_masked (.vec(masked), .idx(ffs_m));
  find_first_set #(.W(CLIENTS), .OW(FW)) u_ffs_all    (.vec(i_req),  .idx(ffs_u));

  assign win_1b  = (ffs_m != '0) ? ffs_m : ffs_u;
  assign win     = IDW'(win_1b - FW'(1));
  assign has_win = |i_req;

  assign rel_ack  = i_ack;
  assign rel_drop = ~i_req[id_q];
  assign rel_to   = (MAX_HOLD > 0) && (cnt_q == CW'(HOLD_LAST));

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    o_timeout = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (has_win) begin
          state_d = ARB_GRANT;
          id_d    = win;
          cnt_d   = '0;
        end
      end
      ARB_GRANT: begin
        if (rel_ack || rel_drop || rel_to) begin
          last_d    = id_q;
          // Timeout is reported only when it is the sole reason for release.
          o_timeout = rel_to && !rel_ack && !rel_drop;
          if (has_win) begin
            id_d  = win;
            cnt_d = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (cnt_q != CW'(CNT_MAX)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    grant_d = '0;
    if (state_d == ARB_GRANT) grant_d[id_d] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ARB_IDLE;
      id_q    <= '0;
      last_q  <= IDW'(CLIENTS - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_id    = id_q;
  assign o_grant_valid = (state_q == ARB_GRANT);

endmodule

// File: tb/tb_arbiter_rr_hold.sv
module tb_arbiter_rr_hold;

  localparam int N    = 8;
  localparam int HOLD = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [N-1:0] i_req;
  logic         i_ack;
  logic [N-1:0] o_grant;
  logic [2:0]   o_grant_id;
  logic         o_grant_valid;
  logic         o_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  arbiter_rr_hold #(.CLIENTS(N), .MAX_HOLD(HOLD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ack(i_ack),
    .o_grant(o_grant), .o_grant_id(o_grant_id),
    .o_grant_valid(o_grant_valid), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are read 1ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_req = '0; i_ack = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
  endtask

  // Reference: search clients in rotating order starting after 'last'.
  function automatic int model_win(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0; i_req = 8'h01; i_ack = 1'b1;
    tick(); tick();
    n_tests++;
    if ({o_grant, o_grant_id, o_grant_valid, o_timeout} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%h id=%0d v=%b to=%b, want all 0",
               o_grant, o_grant_id, o_grant_valid, o_timeout);
    end
    i_rst_n = 1'b1; i_ack = 1'b0;
    tick();
    n_tests++;
    if (o_grant !== 8'h01 || o_grant_id !== 3'd0 || o_grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: got grant=%h id=%0d v=%b, want 01/0/1",
               o_grant, o_grant_id, o_grant_valid);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    i_req = 8'hFF;
    tick();
    n_tests++;
    if (o_grant_id !== 3'd0 || o_grant !== 8'h01) begin
      n_fail++;
      $display("FAIL rot_start: got id=%0d grant=%h, want 0/01", o_grant_id, o_grant);
    end
    i_ack = 1'b1;
    for (int k = 1; k <= N; k++) begin
      logic [2:0]   eid;
      logic [N-1:0] eg;
      eid = 3'(k % N);
      eg  = 8'h01 << (k % N);
      tick();
      n_tests++;
      if (o_grant_id !== eid || o_grant !== eg || o_grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rot_step%0d: got id=%0d grant=%h v=%b, want id=%0d grant=%h v=1",
                 k, o_grant_id, o_grant, o_grant_valid, eid, eg);
      end
    end
    i_ack = 1'b0;
  endtask

  task automatic test_ack_switch();
    do_reset();
    i_req = 8'h08;
    tick();
    i_req = 8'b0010_1000;
    tick();
    n_tests++;
    if (o_grant_id !== 3'd3) begin
      n_fail++;
      $display("FAIL ack_hold3: got id=%0d, want 3", o_grant_id);
    end
    i_ack = 1'b1;
    tick();
    n_tests++;
    if (o_grant_id !== 3'd5 || o_grant !== 8'h20) begin
      n_fail++;
      $display("FAIL ack_to5: got id=%0d grant=%h, want 5/20", o_grant_id, o_grant);
    end
    tick();
    n_tests++;
    if (o_grant_id !== 3'd3 || o_grant !== 8'h08) begin
      n_fail++;
      $display("FAIL ack_back3: got id=%0d grant=%h, want 3/08", o_grant_id, o_grant);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    i_req = 8'h06;
    tick();
    for (int i = 0; i < HOLD; i++) begin
      #1;
      n_tests++;
      if (o_grant_id !== 3'd1 || o_timeout !== (i == HOLD - 1)) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got id=%0d to=%b, want id=1 to=%b",
                 i, o_grant_id, o_timeout, (i == HOLD - 1));
      end
      tick();
    end
    n_tests++;
    if (o_grant_id !== 3'd2 || o_grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_timeout: got id=%0d v=%b, want 2/1", o_grant_id, o_grant_valid);
    end
  endtask

  task automatic test_drop();
    do_reset();
    i_req = 8'h04;
    tick();
    i_req = 8'h00;
    #1;
    n_tests++;
    if (o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_timeout: got %b, want 0", o_timeout);
    end
    tick();
    n_tests++;
    if (o_grant_valid !== 1'b0 || o_grant !== 8'h00) begin
      n_fail++;
      $display("FAIL drop_idle: got v=%b grant=%h, want 0/00", o_grant_valid, o_grant);
    end
    i_req = 8'h04;
    tick();
    n_tests++;
    if (o_grant_id !== 3'd2 || o_grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_regrant: got id=%0d v=%b, want 2/1", o_grant_id, o_grant_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    i_req = 8'hFF; i_ack = 1'b1;
    tick(); tick(); tick();
    i_rst_n = 1'b0;
    tick();
    n_tests++;
    if ({o_grant, o_grant_valid, o_timeout} !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_out: got grant=%h v=%b to=%b, want 0",
               o_grant, o_grant_valid, o_timeout);
    end
    i_rst_n = 1'b1; i_ack = 1'b0;
    tick();
    n_tests++;
    if (o_grant_id !== 3'd0 || o_grant !== 8'h01) begin
      n_fail++;
      $display("FAIL midreset_ptr: got id=%0d grant=%h, want 0/01", o_grant_id, o_grant);
    end
  endtask

  task automatic test_random();
    bit m_valid = 0;
    int m_id = 0, m_cnt = 0, m_last = N - 1;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit exp_to, rel;
      int w;
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0: i_req = '0;
          1: i_req = 8'h01 << $urandom_range(0, N - 1);
          default: i_req = N'($urandom);
        endcase
      end
      i_ack = ($urandom_range(0, 3) == 0);
      #1;
      rel    = m_valid && (i_ack || !i_req[m_id] || m_cnt == HOLD - 1);
      exp_to = m_valid && !i_ack && i_req[m_id] && m_cnt == HOLD - 1;
      n_tests++;
      if (o_timeout !== exp_to) begin
        n_fail++;
        $display("FAIL rnd_timeout c%0d: got %b, want %b", cyc, o_timeout, exp_to);
      end
      if (!m_valid) begin
        w = model_win(m_last, i_req);
        if (w >= 0) begin m_valid = 1; m_id = w; m_cnt = 0; end
      end else if (rel) begin
        m_last = m_id;
        w = model_win(m_last, i_req);
        if (w >= 0) begin m_id = w; m_cnt = 0; end
        else m_valid = 0;
      end else if (m_cnt < HOLD) begin
        m_cnt++;
      end
      tick();
      n_tests++;
      if (o_grant_valid !== m_valid ||
          o_grant !== (m_valid ? (8'h01 << m_id) : 8'h00) ||
          (m_valid && o_grant_id !== 3'(m_id))) begin
        n_fail++;
        $display("FAIL rnd_grant c%0d: got v=%b id=%0d grant=%h, want v=%b id=%0d",
                 cyc, o_grant_valid, o_grant_id, o_grant, m_valid, m_id);
      end
    end
    i_ack = 1'b0; i_req = '0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req = '0; i_ack = 1'b0;
    test_reset();
    test_rotation();
    test_ack_switch();
    test_timeout();
    test_drop();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbiter_rr_hold.md
Name: arbiter_rr_hold

Overview:
Round-robin arbiter that shares one downstream resource among CLIENTS requesters. A grant is held until the owner acknowledges completion, drops its request, or exceeds a hold limit. Winner selection uses the common find-first-set priority scan on a rotating mask. It sits in front of shared datapath resources in the common library, for example a shared bus port or a single leading/trailing-one detector.

Parameters:
CLIENTS, 8, number of requesters (2..32)
MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the timeout
IDW, $clog2(CLIENTS), grant index width (derived; do not override)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset, synchronous, active-low
i_req  input  CLIENTS  per-client request, level, held until served
i_ack  input  1  owner signals transaction complete (valid only while o_grant_valid=1)
o_grant  output  CLIENTS  one-hot grant, registered
o_grant_id  output  IDW  binary index of granted client, registered
o_grant_valid  output  1  a grant is active
o_timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Reset (i_rst_n=0 at posedge): o_grant=0, o_grant_id=0, o_grant_valid=0, o_timeout=0, hold counter=0, last pointer=CLIENTS-1 so client 0 has top priority first. Reset mid-grant drops the grant immediately on that edge.
- States: IDLE, GRANT.
- Selection:
  - masked = i_req & (bits strictly above the last pointer).
  - The winner is the lowest set bit of masked if masked != 0; otherwise the lowest set bit of i_req.
  - The winner is computed combinationally from current i_req.
- IDLE:
  - If |i_req, go to GRANT on the next edge with o_grant=onehot(winner), o_grant_id=winner, o_grant_valid=1, counter=0.
  - Request-to-grant latency is 1 cycle.
- GRANT, release events, priority highest first: i_ack=1; i_req[o_grant_id]=0; counter==MAX_HOLD-1 (when MAX_HOLD>0).
- GRANT, on any release event:
  - The last pointer is set to o_grant_id.
  - o_timeout=1 for one cycle, only when the cause is the timeout and no ack is present.
  - Back-to-back: the next winner is selected in the same cycle using the updated pointer, so the releasing client has lowest priority.
  - If a winner exists, the next grant is registered on the next edge with no bubble. Otherwise go to IDLE and o_grant_valid=0.
- GRANT, no release event: counter increments and the grant is stable. Changes to other clients' requests have no effect.
- i_ack while IDLE is ignored.
- Ack and timeout in the same cycle count as an ack, with no o_timeout pulse.
- Single requester: it is regranted on consecutive transactions with no bubble.
- Counter width is $clog2(MAX_HOLD+1). It saturates and never wraps.
- The last pointer wraps: when last=CLIENTS-1 the mask is empty and selection falls back to plain lowest-set-bit.
- Outputs are invariant: o_grant has at most one bit set; o_grant==0 exactly when o_grant_valid==0.

Decomposition:
- Shared package arb_pkg: typedef of the state enum (ARB_IDLE, ARB_GRANT), and a function building the rotate mask from the pointer.
- Sub-module reuse: instantiate the existing common find_first_set twice, once for masked and once for unmasked. It returns a 1-based index, with 0 meaning no bit set; subtract 1 for the 0-based winner.
- No other sub-modules; the FSM, counter and pointer live in arbiter_rr_hold.

Test Plan:
- Reset, then i_req=8'b0000_0001 at cycle 0 -> o_grant=8'h01, o_grant_id=0, o_grant_valid=1 at cycle 1; all outputs 0 during reset.
- i_req=8'hFF held, i_ack pulsed each grant cycle -> grant ids 0,1,2,...,7,0 on consecutive cycles with no bubble, one-hot every cycle.
- Grant to client 3, i_req=8'b0010_1000, i_ack at cycle 5 -> cycle 6 grant id 5; client 5 acks, client 3 still requesting -> next grant id 3.
- MAX_HOLD=4, i_req=8'h06, no ack -> client 1 granted for exactly 4 cycles, o_timeout pulses on the 4th, then client 2 granted the next cycle.
- Granted client 2 drops i_req[2] without ack, other requests 0 -> o_grant_valid=0 next cycle, o_timeout=0, and the next single request from client 2 is granted with 1-cycle latency.
- Assert i_rst_n=0 mid-grant with i_req=8'hFF -> outputs 0 at that edge; after release client 0 is granted first, proving the pointer reset to CLIENTS-1.
